// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package mdu_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3
  } md_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div0;
  } mdu_res_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mult(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational signed/unsigned 32x32 multiply and divide producing {hi, lo, div0}.
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output mdu_res_t        res_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   div_s;
  logic [XLEN-1:0]   div_u;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   q_u;
  logic [XLEN-1:0]   r_u;
  logic              div0;
  logic              ovf;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
  assign prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

  assign div0 = (b_i == '0);
  assign ovf  = (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

  // Divisors are steered away from zero and the INT_MIN/-1 overflow case.
  assign div_s = (div0 || ovf) ? XLEN'(1) : b_i;
  assign div_u = div0 ? XLEN'(1) : b_i;

  assign q_s = $signed(a_i) / $signed(div_s);
  assign r_s = $signed(a_i) % $signed(div_s);
  assign q_u = a_i / div_u;
  assign r_u = a_i % div_u;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT: begin
        res_o.hi = prod_s[2*XLEN-1:XLEN];
        res_o.lo = prod_s[XLEN-1:0];
      end
      MD_MULTU: begin
        res_o.hi = prod_u[2*XLEN-1:XLEN];
        res_o.lo = prod_u[XLEN-1:0];
      end
      MD_DIV: begin
        res_o.div0 = div0;
        if (ovf) begin
          res_o.hi = '0;
          res_o.lo = a_i;
        end else begin
          res_o.hi = r_s;
          res_o.lo = q_s;
        end
      end
      MD_DIVU: begin
        res_o.div0 = div0;
        res_o.hi   = r_u;
        res_o.lo   = q_u;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mul/div sequencer beside the E-stage ALU; owns the HI/LO registers.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] md_op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            hilo_wr,
  input  logic            hilo_sel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_res_t        pend_q, pend_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  mdu_res_t        arith_res;

  mdu_ctrl_arith u_arith (
    .op_i  (md_op),
    .a_i   (A),
    .b_i   (B),
    .res_o (arith_res)
  );

  // Result is computed at accept time; the counter only models latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          if (op_valid(md_op)) begin
            pend_d  = arith_res;
            cnt_d   = op_is_mult(md_op) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
            state_d = MDU_RUN;
            busy_d  = 1'b1;
          end
        end else if (hilo_wr) begin
          if (hilo_sel) hi_d = A;
          else          lo_d = A;
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (!pend_q.div0) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign rdata = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors, corner sequences and a random model run.
module tb_mdu_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_wr;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .hilo_wr  (hilo_wr),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .HI       (HI),
    .LO       (LO)
  );

  // The pipeline must never issue start or hilo_wr while the unit is busy.
  always @(posedge clk) begin
    if (!reset && busy && (start || hilo_wr)) begin
      bad++;
      $display("FAIL protocol: start/hilo_wr issued while busy");
    end
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        pre;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Reference: {hi, lo} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); return p; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
      OP_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
    hilo_wr = 1'b1; hilo_sel = 1'b1; A = hi;
    step();
    hilo_sel = 1'b0; A = lo;
    step();
    hilo_wr = 1'b0; A = '0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    int win;
    n = (op == OP_MULT || op == OP_MULTU) ? int'(MULT_N) : int'(DIV_N);
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0; A = '0; B = '0;
    win = (busy === 1'b1 && done === 1'b0) ? 1 : 0;
    for (int k = 1; k < n; k++) begin
      step();
      if (busy === 1'b1 && done === 1'b0) win++;
    end
    chk({nm, " busy_window"}, 32'(win), 32'(n));
    step();
    chk({nm, " done_pulse"}, 32'(done), 32'd1);
    chk({nm, " busy_clear"}, 32'(busy), 32'd0);
    chk({nm, " HI"}, HI, exp_hi);
    chk({nm, " LO"}, LO, exp_lo);
    hilo_sel = 1'b0; #1;
    chk({nm, " rdata_lo"}, rdata, exp_lo);
    hilo_sel = 1'b1; #1;
    chk({nm, " rdata_hi"}, rdata, exp_hi);
    step();
    chk({nm, " done_drop"}, 32'(done), 32'd0);
  endtask

  vec_t        vecs [7];
  logic [63:0] m;
  logic [31:0] m_hi, m_lo;
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  int          kind;
  int          pulses;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; A = '0; B = '0;
    hilo_wr = 1'b0; hilo_sel = 1'b0;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 32'd0, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,
                32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 32'd0, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,
                32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{OP_DIVU,  32'd5,         32'd0,        1'b1, 32'h11, 32'h22,
                32'h0000_0011, 32'h0000_0022};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd7,        1'b0, 32'd0, 32'd0,
                32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'd0, 32'd0,
                32'h0000_0001, 32'hFFFF_FFFD};

    step(); step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre) preload(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // mthi then mtlo each touch only their own register.
    hilo_wr = 1'b1; hilo_sel = 1'b1; A = 32'hAAAA_0001;
    step();
    chk("mthi HI", HI, 32'hAAAA_0001);
    chk("mthi LO kept", LO, 32'hFFFF_FFFD);
    hilo_sel = 1'b0; A = 32'h5555_0002;
    step();
    hilo_wr = 1'b0;
    chk("mtlo LO", LO, 32'h5555_0002);
    chk("mtlo HI kept", HI, 32'hAAAA_0001);

    // Unknown op is a no-op.
    start = 1'b1; md_op = 3'd6; A = 32'd9; B = 32'd9;
    step();
    start = 1'b0;
    chk("unk busy", 32'(busy), 32'd0);
    step();
    chk("unk done", 32'(done), 32'd0);
    chk("unk HI", HI, 32'hAAAA_0001);

    // start and hilo_wr together: start wins, the write is dropped.
    start = 1'b1; hilo_wr = 1'b1; hilo_sel = 1'b1; md_op = OP_MULT; A = 32'd4; B = 32'd5;
    step();
    start = 1'b0; hilo_wr = 1'b0;
    chk("both HI kept", HI, 32'hAAAA_0001);
    repeat (MULT_N) step();
    chk("both HI", HI, 32'd0);
    chk("both LO", LO, 32'd20);
    step();

    // Reset mid-operation aborts with no commit.
    start = 1'b1; md_op = OP_DIV; A = 32'd100; B = 32'd3;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid HI", HI, 32'd0);
    chk("rst_mid LO", LO, 32'd0);
    pulses = (done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    chk("rst_mid no_done", 32'(pulses), 32'd0);
    run_op("after_rst", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

    // Random phase against the reference model, from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      if (kind <= 3) begin
        rop = 3'(kind);
        m = model(rop, ra, rb, m_hi, m_lo);
        run_op($sformatf("rnd%0d", it), rop, ra, rb, m[63:32], m[31:0]);
        m_hi = m[63:32]; m_lo = m[31:0];
      end else if (kind == 4) begin
        start = 1'b1; md_op = 3'($urandom_range(4, 7)); A = ra; B = rb;
        step();
        start = 1'b0;
        chk($sformatf("rnd%0d unk busy", it), 32'(busy), 32'd0);
        chk($sformatf("rnd%0d unk LO", it), LO, m_lo);
      end else if (kind <= 6) begin
        hilo_wr = 1'b1; hilo_sel = (kind == 6); A = ra;
        step();
        hilo_wr = 1'b0;
        if (kind == 6) m_hi = ra;
        else           m_lo = ra;
        chk($sformatf("rnd%0d mt HI", it), HI, m_hi);
        chk($sformatf("rnd%0d mt LO", it), LO, m_lo);
      end else begin
        hilo_sel = 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("rnd%0d rdata", it), rdata, hilo_sel ? m_hi : m_lo);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
